// File: rtl/spi_frame_sequencer.sv
// SPI configuration frame sequencer: decodes opcode/address/burst bytes from the
// spi_slave deserialiser, drives config-memory address/write-enable and owns the ready flags.
module spi_frame_sequencer #(
    parameter int MEM_DEPTH = 224,
    parameter int ADDR_W    = 8
) (
    input  logic              SCLK,
    input  logic              RESET,
    input  logic              SS,
    input  logic              data_valid,
    input  logic [7:0]        received_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              clk_div_ready,
    output logic              input_spike_ready,
    output logic              debug_config_ready,
    output logic              frame_active,
    output logic              cmd_err
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_H,
        ADDR_L,
        WR_DATA,
        RD_DATA,
        DISCARD
    } state_t;

    typedef enum logic {
        OP_WR,
        OP_RD
    } op_t;

    localparam logic [15:0] DEPTH16 = 16'(MEM_DEPTH);
    localparam logic [15:0] LAST16  = 16'(MEM_DEPTH - 1);

    state_t      state;
    op_t         op;
    logic [15:0] addr;
    logic        in_range;
    logic [15:0] addr_inc;

    assign in_range = (addr < DEPTH16);

    // Bursts wrap inside the memory; an already out-of-range address just counts on.
    assign addr_inc = (addr == LAST16) ? 16'h0000 : addr + 16'h0001;

    assign mem_addr     = addr[ADDR_W-1:0];
    assign mem_we       = data_valid & (state == WR_DATA) & in_range & ~SS;
    assign mem_wdata    = received_data;
    assign frame_active = (state != IDLE);

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values, matching the combinational mem_we.
    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            state              <= IDLE;
            op                 <= OP_WR;
            addr               <= 16'h0000;
            clk_div_ready      <= 1'b0;
            input_spike_ready  <= 1'b0;
            debug_config_ready <= 1'b0;
            cmd_err            <= 1'b0;
        end else if (SS) begin
            state <= IDLE;
        end else if (data_valid) begin
            case (state)
                IDLE: begin
                    state <= DISCARD;
                    case (received_data)
                        8'h01: begin
                            op    <= OP_WR;
                            state <= ADDR_H;
                        end
                        8'h03: begin
                            op    <= OP_RD;
                            state <= ADDR_H;
                        end
                        8'h10:   clk_div_ready      <= 1'b1;
                        8'h11:   clk_div_ready      <= 1'b0;
                        8'h20:   input_spike_ready  <= 1'b1;
                        8'h21:   input_spike_ready  <= 1'b0;
                        8'h30:   debug_config_ready <= 1'b1;
                        8'h31:   debug_config_ready <= 1'b0;
                        8'h7F:   cmd_err            <= 1'b0;
                        default: cmd_err            <= 1'b1;
                    endcase
                end
                ADDR_H: begin
                    addr[15:8] <= received_data;
                    state      <= ADDR_L;
                end
                ADDR_L: begin
                    addr[7:0] <= received_data;
                    state     <= (op == OP_WR) ? WR_DATA : RD_DATA;
                end
                // Read bytes are dummies; only the address advances.
                WR_DATA, RD_DATA: begin
                    if (!in_range) cmd_err <= 1'b1;
                    addr <= addr_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Self-checking bench for spi_frame_sequencer: directed frames plus random frames
// compared against a byte-index frame model and a reference memory image.
module tb_spi_frame_sequencer;

    localparam int MEM_DEPTH = 224;
    localparam int ADDR_W    = 8;

    logic              SCLK = 1'b0;
    logic              RESET;
    logic              SS;
    logic              data_valid;
    logic [7:0]        received_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic              clk_div_ready;
    logic              input_spike_ready;
    logic              debug_config_ready;
    logic              frame_active;
    logic              cmd_err;

    spi_frame_sequencer #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
        .SCLK               (SCLK),
        .RESET              (RESET),
        .SS                 (SS),
        .data_valid         (data_valid),
        .received_data      (received_data),
        .mem_addr           (mem_addr),
        .mem_we             (mem_we),
        .mem_wdata          (mem_wdata),
        .clk_div_ready      (clk_div_ready),
        .input_spike_ready  (input_spike_ready),
        .debug_config_ready (debug_config_ready),
        .frame_active       (frame_active),
        .cmd_err            (cmd_err)
    );

    always #5 SCLK = ~SCLK;

    // Configuration memory as the DUT sees it.
    logic [7:0] tb_mem [0:255];
    int         we_count = 0;
    always @(posedge SCLK) begin
        if (mem_we) begin
            tb_mem[mem_addr] <= mem_wdata;
            we_count         <= we_count + 1;
        end
    end

    // Reference model: frame position counter, opcode, 16-bit address, flags.
    logic [7:0] ref_mem     [0:255];
    bit         ref_written [0:255];
    int         m_addr, m_idx, m_op;
    bit         m_clk, m_spk, m_dbg, m_err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] fr [$];
    logic [7:0] flag_ops [7] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h7F};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = 0;
        m_idx  = 0;
        m_op   = 0;
        m_clk  = 0;
        m_spk  = 0;
        m_dbg  = 0;
        m_err  = 0;
    endtask

    task automatic check_flags(input string tag);
        check(tag, {clk_div_ready, input_spike_ready, debug_config_ready, cmd_err},
              {m_clk, m_spk, m_dbg, m_err});
    endtask

    // One byte with data_valid high for exactly one rising edge.
    task automatic put_byte(input logic [7:0] b);
        bit in_rng;
        bit exp_we;
        @(negedge SCLK);
        SS            = 1'b0;
        data_valid    = 1'b1;
        received_data = b;
        #1;
        in_rng = (m_addr < MEM_DEPTH);
        exp_we = (m_idx >= 3) && (m_op == 1) && in_rng;
        check("mem_we", mem_we, exp_we);
        check("mem_addr", mem_addr, m_addr % 256);
        check("mem_wdata", mem_wdata, b);
        check("frame_active", frame_active, m_idx > 0);
        check_flags("flags");
        if (m_idx >= 3 && m_op == 3 && in_rng && ref_written[m_addr])
            check("rd_data", tb_mem[mem_addr], ref_mem[m_addr]);

        if (m_idx == 0) begin
            m_op = 0;
            case (b)
                8'h01:   m_op  = 1;
                8'h03:   m_op  = 3;
                8'h10:   m_clk = 1;
                8'h11:   m_clk = 0;
                8'h20:   m_spk = 1;
                8'h21:   m_spk = 0;
                8'h30:   m_dbg = 1;
                8'h31:   m_dbg = 0;
                8'h7F:   m_err = 0;
                default: m_err = 1;
            endcase
        end else if (m_op != 0) begin
            if (m_idx == 1) begin
                m_addr = int'(b) * 256 + (m_addr % 256);
            end else if (m_idx == 2) begin
                m_addr = (m_addr / 256) * 256 + int'(b);
            end else begin
                if (!in_rng) begin
                    m_err = 1;
                end else if (m_op == 1) begin
                    ref_mem[m_addr]     = b;
                    ref_written[m_addr] = 1;
                end
                m_addr = (m_addr == MEM_DEPTH - 1) ? 0 : (m_addr + 1) % 65536;
            end
        end
        m_idx++;
    endtask

    task automatic idle_cycle();
        @(negedge SCLK);
        data_valid    = 1'b0;
        received_data = 8'($urandom);
        #1;
        check("idle_we", mem_we, 0);
    endtask

    // Raise SS (sometimes with a competing data_valid), then check the idle state.
    task automatic end_frame();
        @(negedge SCLK);
        SS            = 1'b1;
        data_valid    = 1'($urandom_range(0, 1));
        received_data = 8'($urandom);
        #1;
        check("ss_we", mem_we, 0);
        @(negedge SCLK);
        data_valid = 1'b0;
        #1;
        check("idle_active", frame_active, 0);
        check_flags("flags_end");
        check("addr_end", mem_addr, m_addr % 256);
        m_idx = 0;
        m_op  = 0;
    endtask

    task automatic send_frame(input logic [7:0] bytes [$], input bit gaps, input bit close);
        foreach (bytes[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) idle_cycle();
            put_byte(bytes[i]);
        end
        if (close) end_frame();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        logic [7:0] opc;
        int a, len, nb;

        for (int i = 0; i < 256; i++) begin
            ref_mem[i]     = 8'h00;
            ref_written[i] = 0;
        end
        model_reset();
        RESET         = 1'b1;
        SS            = 1'b1;
        data_valid    = 1'b0;
        received_data = 8'h00;
        repeat (2) @(negedge SCLK);
        #1;
        check("rst_addr", mem_addr, 0);
        check("rst_we", mem_we, 0);
        check("rst_active", frame_active, 0);
        check_flags("rst_flags");
        @(negedge SCLK);
        RESET = 1'b0;

        // Write burst, back-to-back bytes.
        w0 = we_count;
        fr = {8'h01, 8'h00, 8'h05, 8'hAA, 8'hBB, 8'hCC};
        send_frame(fr, 0, 1);
        check("burst_we_cnt", we_count - w0, 3);
        check("burst_addr", mem_addr, 8);
        check("burst_m5", tb_mem[5], 8'hAA);
        check("burst_m6", tb_mem[6], 8'hBB);
        check("burst_m7", tb_mem[7], 8'hCC);

        // Wrap from the last location to 0.
        fr = {8'h01, 8'h00, 8'hDF, 8'h11, 8'h22};
        send_frame(fr, 0, 1);
        check("wrap_m223", tb_mem[223], 8'h11);
        check("wrap_m0", tb_mem[0], 8'h22);
        check("wrap_err", cmd_err, 0);

        // Read burst of preloaded data.
        fr = {8'h01, 8'h00, 8'h0A, 8'h3C, 8'h4D, 8'h5E};
        send_frame(fr, 0, 1);
        w0 = we_count;
        fr = {8'h03, 8'h00, 8'h0A, 8'($urandom), 8'($urandom), 8'($urandom)};
        send_frame(fr, 0, 1);
        check("read_we_cnt", we_count - w0, 0);
        check("read_addr", mem_addr, 13);

        // Ready flags; trailing bytes in a flag frame are ignored.
        fr = {8'h10, 8'h55, 8'h11};
        send_frame(fr, 0, 1);
        fr = {8'h20};
        send_frame(fr, 0, 1);
        fr = {8'h31, 8'h30};
        send_frame(fr, 0, 1);
        check("flags3", {clk_div_ready, input_spike_ready, debug_config_ready}, 3'b110);
        fr = {8'h11};
        send_frame(fr, 0, 1);
        check("flags4_clk", clk_div_ready, 0);

        // Errors.
        fr = {8'h55, 8'h01, 8'h02};
        send_frame(fr, 0, 1);
        check("bad_op_err", cmd_err, 1);
        fr = {8'h7F};
        send_frame(fr, 0, 1);
        check("clr_err", cmd_err, 0);
        w0 = we_count;
        fr = {8'h01, 8'h01, 8'h00, 8'h77};
        send_frame(fr, 0, 1);
        check("oor_we_cnt", we_count - w0, 0);
        check("oor_err", cmd_err, 1);
        fr = {8'h7F};
        send_frame(fr, 0, 1);

        // SS raised in ADDR_H; next byte is an opcode.
        fr = {8'h01};
        send_frame(fr, 0, 1);
        fr = {8'h21};
        send_frame(fr, 0, 1);
        check("abort_spk", input_spike_ready, 0);

        // Reset in the middle of a write burst.
        fr = {8'h01, 8'h00, 8'h20, 8'h99};
        send_frame(fr, 0, 0);
        @(negedge SCLK);
        data_valid    = 1'b1;
        received_data = 8'h5A;
        #1;
        RESET = 1'b1;
        #1;
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_active", frame_active, 0);
        check("mid_rst_flags", {clk_div_ready, input_spike_ready, debug_config_ready, cmd_err}, 0);
        @(negedge SCLK);
        RESET      = 1'b0;
        data_valid = 1'b0;
        SS         = 1'b1;
        model_reset();
        check("mid_rst_m21", tb_mem[8'h21], 8'h00);
        fr = {8'h01, 8'h00, 8'h30, 8'h42};
        send_frame(fr, 0, 1);
        check("post_rst_m30", tb_mem[8'h30], 8'h42);

        // Random frames with gaps between bytes.
        for (int f = 0; f < 150; f++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: opc = 8'h01;
                3, 4:    opc = 8'h03;
                5:       opc = flag_ops[$urandom_range(0, 6)];
                6:       opc = 8'($urandom);
                default: opc = 8'h7F;
            endcase
            case ($urandom_range(0, 5))
                0:       a = MEM_DEPTH - 2 + int'($urandom_range(0, 1));
                1:       a = 16'h0100 + int'($urandom_range(0, 3));
                2:       a = 16'hFFFF;
                default: a = int'($urandom_range(0, MEM_DEPTH - 1));
            endcase
            len = int'($urandom_range(0, 6));
            fr  = {opc, 8'(a >> 8), 8'(a)};
            for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
            if ($urandom_range(0, 5) == 0) begin
                nb = int'($urandom_range(1, 2));
                while (fr.size() > nb) void'(fr.pop_back());
            end
            send_frame(fr, 1, 1);
        end

        for (int i = 0; i < MEM_DEPTH; i++)
            if (ref_written[i]) check("final_mem", tb_mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
